// File: rtl/am_sample_buffer_pkg.sv
// ============================================================================
// Module      : am_sample_buffer_pkg
// Description : Shared AM sample-path defines, state encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package am_sample_buffer_pkg;

    localparam int unsigned AM_DATA_W    = 8;
    localparam int unsigned AM_PWM_STEPS = 32'd1 << AM_DATA_W;
    localparam int unsigned AM_IDLE_LEVEL = AM_PWM_STEPS / 2;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } am_state_e;

    // Mid-scale code: zero modulation on the carrier.
    function automatic int unsigned am_idle_level(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/am_sample_buffer_if.sv
// ============================================================================
// Module      : am_sample_buffer_if
// Description : Producer/modulator-facing signal bundle of the sample buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface am_sample_buffer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              sample_req;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic [ADDR_W:0]   level;
    logic              underflow;
    logic              overflow;
    logic              clr_flags;

    modport master (
        output wr_valid, wr_data, sample_req, clr_flags,
        input  wr_ready, sample, sample_valid, level, underflow, overflow
    );

    modport slave (
        input  wr_valid, wr_data, sample_req, clr_flags,
        output wr_ready, sample, sample_valid, level, underflow, overflow
    );
endinterface

`default_nettype wire

// File: rtl/sample_fifo_ram.sv
// ============================================================================
// Module      : sample_fifo_ram
// Description : Simple dual-port sample store, registered read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_fifo_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  wire logic              clk,
    input  wire logic              we_i,
    input  wire logic [ADDR_W-1:0] waddr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic              re_i,
    input  wire logic [ADDR_W-1:0] raddr_i,
    output      logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/am_sample_buffer.sv
// ============================================================================
// Module      : am_sample_buffer
// Description : Prefilling sample FIFO feeding an AM PWM modulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module am_sample_buffer
    import am_sample_buffer_pkg::*;
#(
    parameter int unsigned DATA_W     = AM_DATA_W,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned PREFILL    = 8,
    parameter int unsigned IDLE_LEVEL = am_idle_level(DATA_W)
) (
    input wire logic          clk,
    input wire logic          rst,
    am_sample_buffer_if.slave bus
);
    localparam logic [DATA_W-1:0] c_idle    = DATA_W'(IDLE_LEVEL);
    localparam logic [ADDR_W:0]   c_depth   = (ADDR_W+1)'(32'd1 << ADDR_W);
    localparam logic [ADDR_W:0]   c_prefill = (ADDR_W+1)'(PREFILL);

    am_state_e         state_q, state_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              sel_ram_q, sel_ram_d;
    logic              sample_valid_q, sample_valid_d;
    logic              underflow_q, underflow_d;
    logic              overflow_q, overflow_d;

    logic              w_full;
    logic              w_empty;
    logic              w_run;
    logic              w_push;
    logic              w_pop;
    logic              w_under;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_full  = (level_q == c_depth);
    assign w_empty = (level_q == '0);
    assign w_run   = (state_q == ST_RUN);
    assign w_push  = bus.wr_valid && !w_full;
    assign w_pop   = bus.sample_req && w_run && !w_empty;
    assign w_under = bus.sample_req && w_run && w_empty;

    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        sel_ram_d      = sel_ram_q;
        sample_valid_d = bus.sample_req;
        underflow_d    = underflow_q | w_under;
        overflow_d     = overflow_q | (bus.wr_valid && w_full);

        case (state_q)
            ST_FILL: if (level_q >= c_prefill) state_d = ST_RUN;
            ST_RUN:  if (w_under)              state_d = ST_FILL;
            default:                           state_d = ST_FILL;
        endcase

        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        // The RAM read register holds the popped value; idle strobes switch the mux away.
        if (bus.sample_req) sel_ram_d = w_pop;

        if (bus.clr_flags) begin
            underflow_d = 1'b0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_FILL;
            level_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            sel_ram_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            underflow_q    <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            sel_ram_q      <= sel_ram_d;
            sample_valid_q <= sample_valid_d;
            underflow_q    <= underflow_d;
            overflow_q     <= overflow_d;
        end
    end

    sample_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .re_i    (w_pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_ram_rdata)
    );

    assign bus.wr_ready     = !w_full;
    assign bus.sample       = sel_ram_q ? w_ram_rdata : c_idle;
    assign bus.sample_valid = sample_valid_q;
    assign bus.level        = level_q;
    assign bus.underflow    = underflow_q;
    assign bus.overflow     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_am_sample_buffer.sv
// ============================================================================
// Module      : tb_am_sample_buffer
// Description : Scoreboard bench for am_sample_buffer at default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_am_sample_buffer;

    localparam int        DEPTH   = 16;
    localparam int        PREFILL = 8;
    localparam logic [7:0] IDLE   = 8'h80;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    am_sample_buffer_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    am_sample_buffer #(
        .DATA_W     (8),
        .ADDR_W     (4),
        .PREFILL    (PREFILL),
        .IDLE_LEVEL (128)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    bit         m_run;
    bit         m_uf;
    bit         m_ov;
    logic [7:0] last_sample;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Entered and left at posedge+1: drive one cycle, update the model, check after the edge.
    task automatic step(input bit wv, input logic [7:0] wd, input bit req, input bit clr);
        int lvl;
        bit rdy;
        bus.wr_valid   = wv;
        bus.wr_data    = wd;
        bus.sample_req = req;
        bus.clr_flags  = clr;
        lvl = mq.size();
        rdy = (lvl != DEPTH);
        chk("wr_ready", {31'd0, bus.wr_ready}, {31'd0, rdy});

        if (req) begin
            if (m_run && lvl > 0) begin
                exp_q.push_back(mq.pop_front());
            end else begin
                exp_q.push_back(IDLE);
                if (m_run) m_uf = 1'b1;
            end
        end
        if (!m_run && lvl >= PREFILL)        m_run = 1'b1;
        else if (m_run && req && lvl == 0)   m_run = 1'b0;
        if (wv && rdy)  mq.push_back(wd);
        if (wv && !rdy) m_ov = 1'b1;
        if (clr) begin
            m_uf = 1'b0;
            m_ov = 1'b0;
        end

        @(posedge clk);
        #1;
        chk("level", {27'd0, bus.level}, mq.size());
        chk("underflow", {31'd0, bus.underflow}, {31'd0, m_uf});
        chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ov});
        chk("sample_valid", {31'd0, bus.sample_valid}, {31'd0, req});
        if (bus.sample_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sample: valid strobe with no pending request (t=%0t)", $time);
            end else begin
                last_sample = exp_q.pop_front();
                chk("sample", {24'd0, bus.sample}, {24'd0, last_sample});
            end
        end else begin
            chk("sample_hold", {24'd0, bus.sample}, {24'd0, last_sample});
        end
        exp_q.delete();
    endtask

    // Asserted between edges so the outputs are observed clearing asynchronously.
    task automatic do_reset();
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.sample_req = 1'b0;
        bus.clr_flags  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_sample", {24'd0, bus.sample}, {24'd0, IDLE});
        chk("rst_valid", {31'd0, bus.sample_valid}, 32'd0);
        chk("rst_level", {27'd0, bus.level}, 32'd0);
        chk("rst_underflow", {31'd0, bus.underflow}, 32'd0);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        exp_q.delete();
        m_run = 1'b0;
        m_uf  = 1'b0;
        m_ov  = 1'b0;
        last_sample = IDLE;
        #1;
        chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.sample_req = 1'b0;
        bus.clr_flags  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Prefill then periodic playback, ending in an underflow.
        for (int c = 0; c < 170; c++) begin
            step(c < 8, 8'(8'h10 + c), (c % 16) == 15, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Fill to full, overflow, clear racing a new overflow, drain past empty.
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous write and pop at level 5 in RUN.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset with data in flight, then replay from a clean FIFO.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming with pointer wrap.
        do_reset();
        for (int c = 0; c < 60; c++) begin
            step(c < 40, 8'(c * 7 + 3), c >= 8, 1'b0);
        end

        // Random traffic.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 40) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
